// File: rtl/vending_fsm_param_if.sv
// Groups the vending machine's coin, change-hopper and status signals.
// The master side drives the coin/cancel/hopper inputs; the slave side is the FSM.
interface vending_fsm_param_if #(
   parameter int unsigned CREDIT_W = 8
);
   logic                coin_valid;
   logic [1:0]          coin_sel;
   logic                cancel;
   logic                change_ready;
   logic                coin_accept;
   logic                coin_reject;
   logic                dispense;
   logic                change_valid;
   logic                busy;
   logic [CREDIT_W-1:0] credit;

   modport master (
      output coin_valid,
      output coin_sel,
      output cancel,
      output change_ready,
      input  coin_accept,
      input  coin_reject,
      input  dispense,
      input  change_valid,
      input  busy,
      input  credit
   );

   modport slave (
      input  coin_valid,
      input  coin_sel,
      input  cancel,
      input  change_ready,
      output coin_accept,
      output coin_reject,
      output dispense,
      output change_valid,
      output busy,
      output credit
   );
endinterface

// File: rtl/vending_fsm_param.sv
// Parameterised vending machine controller: collects coins, vends one item at PRICE,
// then pays change (or a cancel refund) one CHANGE_UNIT coin per hopper handshake.
module vending_fsm_param #(
   parameter int unsigned CREDIT_W    = 8,
   parameter int unsigned PRICE       = 15,
   parameter int unsigned DEN0        = 1,
   parameter int unsigned DEN1        = 2,
   parameter int unsigned DEN2        = 5,
   parameter int unsigned DEN3        = 10,
   parameter int unsigned MAX_CREDIT  = 50,
   parameter int unsigned CHANGE_UNIT = 1
) (
   input  logic                  clock,
   input  logic                  reset_n,
   vending_fsm_param_if.slave    bus
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_COLLECT = 3'd1,
      S_VEND    = 3'd2,
      S_CHANGE  = 3'd3,
      S_REFUND  = 3'd4
   } state_t;

   // Coin acceptance is judged one bit wider than the credit register so it cannot wrap.
   localparam logic [CREDIT_W:0]   MAX_X    = (CREDIT_W + 1)'(MAX_CREDIT);
   localparam logic [CREDIT_W:0]   PRICE_X  = (CREDIT_W + 1)'(PRICE);
   localparam logic [CREDIT_W:0]   DEN0_X   = (CREDIT_W + 1)'(DEN0);
   localparam logic [CREDIT_W:0]   DEN1_X   = (CREDIT_W + 1)'(DEN1);
   localparam logic [CREDIT_W:0]   DEN2_X   = (CREDIT_W + 1)'(DEN2);
   localparam logic [CREDIT_W:0]   DEN3_X   = (CREDIT_W + 1)'(DEN3);
   localparam logic [CREDIT_W-1:0] PRICE_LO = CREDIT_W'(PRICE);
   localparam logic [CREDIT_W-1:0] UNIT_LO  = CREDIT_W'(CHANGE_UNIT);

   state_t              r_state;
   state_t              w_stateNext;
   logic [CREDIT_W-1:0] r_credit;
   logic [CREDIT_W-1:0] w_creditNext;
   logic                r_coinAccept;
   logic                r_coinReject;
   logic                w_acceptNext;
   logic                w_rejectNext;
   logic [CREDIT_W:0]   w_coinValue;
   logic [CREDIT_W:0]   w_sum;

   always_comb begin
      w_coinValue = DEN0_X;
      case (bus.coin_sel)
         2'd0:    w_coinValue = DEN0_X;
         2'd1:    w_coinValue = DEN1_X;
         2'd2:    w_coinValue = DEN2_X;
         default: w_coinValue = DEN3_X;
      endcase
   end

   assign w_sum = {1'b0, r_credit} + w_coinValue;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_stateNext;
      end
   end

   always_comb begin
      w_stateNext  = r_state;
      w_creditNext = r_credit;
      w_acceptNext = 1'b0;
      w_rejectNext = 1'b0;
      case (r_state)
         S_IDLE, S_COLLECT: begin
            // A cancel with credit outranks a simultaneous coin, which is handed back.
            if ((r_state == S_COLLECT) && bus.cancel && (r_credit != '0)) begin
               w_stateNext  = S_REFUND;
               w_rejectNext = bus.coin_valid;
            end else if (bus.coin_valid) begin
               if (w_sum > MAX_X) begin
                  w_rejectNext = 1'b1;
               end else begin
                  w_acceptNext = 1'b1;
                  w_creditNext = w_sum[CREDIT_W-1:0];
                  w_stateNext  = (w_sum >= PRICE_X) ? S_VEND : S_COLLECT;
               end
            end
         end
         S_VEND: begin
            w_rejectNext = bus.coin_valid;
            if (r_credit > PRICE_LO) begin
               w_creditNext = r_credit - PRICE_LO;
               w_stateNext  = S_CHANGE;
            end else begin
               w_creditNext = '0;
               w_stateNext  = S_IDLE;
            end
         end
         S_CHANGE, S_REFUND: begin
            w_rejectNext = bus.coin_valid;
            if (bus.change_ready) begin
               if (r_credit > UNIT_LO) begin
                  w_creditNext = r_credit - UNIT_LO;
               end else begin
                  w_creditNext = '0;
                  w_stateNext  = S_IDLE;
               end
            end
         end
         default: begin
            w_stateNext  = S_IDLE;
            w_creditNext = '0;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_credit     <= '0;
         r_coinAccept <= 1'b0;
         r_coinReject <= 1'b0;
      end else begin
         r_credit     <= w_creditNext;
         r_coinAccept <= w_acceptNext;
         r_coinReject <= w_rejectNext;
      end
   end

   assign bus.coin_accept  = r_coinAccept;
   assign bus.coin_reject  = r_coinReject;
   assign bus.dispense     = (r_state == S_VEND);
   assign bus.change_valid = (r_state == S_CHANGE) || (r_state == S_REFUND);
   assign bus.busy         = (r_state == S_VEND) || (r_state == S_CHANGE) || (r_state == S_REFUND);
   assign bus.credit       = r_credit;

endmodule

// File: tb/tb_vending_fsm_param.sv
// Randomised and directed bench for vending_fsm_param: two instances (MAX_CREDIT 50 and 20)
// share stimulus and are each checked every cycle against a credit/phase model.
module tb_vending_fsm_param;

   localparam int W     = 8;
   localparam int PRICE = 15;
   localparam int UNIT  = 1;
   localparam int MAX_A = 50;
   localparam int MAX_B = 20;

   typedef struct {
      int credit;
      bit vend;
      bit paying;
      bit acc;
      bit rej;
   } model_t;

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic       coinValid = 1'b0;
   logic [1:0] coinSel = 2'd0;
   logic       cancel = 1'b0;
   logic       changeReady = 1'b1;

   int     errors = 0;
   int     checks = 0;
   model_t mA = '{default: 0};
   model_t mB = '{default: 0};

   always #5 clock = ~clock;

   vending_fsm_param_if #(.CREDIT_W(W)) busA ();
   vending_fsm_param_if #(.CREDIT_W(W)) busB ();

   assign busA.coin_valid   = coinValid;
   assign busA.coin_sel     = coinSel;
   assign busA.cancel       = cancel;
   assign busA.change_ready = changeReady;
   assign busB.coin_valid   = coinValid;
   assign busB.coin_sel     = coinSel;
   assign busB.cancel       = cancel;
   assign busB.change_ready = changeReady;

   vending_fsm_param #(
      .CREDIT_W(W), .PRICE(PRICE), .DEN0(1), .DEN1(2), .DEN2(5), .DEN3(10),
      .MAX_CREDIT(MAX_A), .CHANGE_UNIT(UNIT)
   ) dutA (
      .clock(clock),
      .reset_n(reset_n),
      .bus(busA)
   );

   vending_fsm_param #(
      .CREDIT_W(W), .PRICE(PRICE), .DEN0(1), .DEN1(2), .DEN2(5), .DEN3(10),
      .MAX_CREDIT(MAX_B), .CHANGE_UNIT(UNIT)
   ) dutB (
      .clock(clock),
      .reset_n(reset_n),
      .bus(busB)
   );

   function automatic int denOf(input logic [1:0] s);
      case (s)
         2'd0:    return 1;
         2'd1:    return 2;
         2'd2:    return 5;
         default: return 10;
      endcase
   endfunction

   // One clock of machine behaviour: vend pays PRICE, payout drains units, otherwise take coins.
   function automatic model_t modelStep(input model_t m, input bit cv, input logic [1:0] sel,
                                        input bit cn, input bit rdy, input int maxC);
      model_t n;
      n     = m;
      n.acc = 1'b0;
      n.rej = 1'b0;
      if (m.vend) begin
         n.credit = m.credit - PRICE;
         n.vend   = 1'b0;
         n.paying = (n.credit > 0);
         n.rej    = cv;
      end else if (m.paying) begin
         n.rej = cv;
         if (rdy) n.credit = m.credit - UNIT;
         if (n.credit == 0) n.paying = 1'b0;
      end else if (cn && m.credit > 0) begin
         n.paying = 1'b1;
         n.rej    = cv;
      end else if (cv) begin
         if (m.credit + denOf(sel) <= maxC) begin
            n.credit = m.credit + denOf(sel);
            n.acc    = 1'b1;
            n.vend   = (n.credit >= PRICE);
         end else begin
            n.rej = 1'b1;
         end
      end
      return n;
   endfunction

   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         mA <= '{default: 0};
         mB <= '{default: 0};
      end else begin
         mA <= modelStep(mA, coinValid, coinSel, cancel, changeReady, MAX_A);
         mB <= modelStep(mB, coinValid, coinSel, cancel, changeReady, MAX_B);
      end
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic compareInst(input string tag, input logic acc, input logic rej, input logic disp,
                              input logic cv, input logic bsy, input logic [W-1:0] cr,
                              input model_t m);
      checkOutput({tag, ".coin_accept"}, int'(acc), int'(m.acc));
      checkOutput({tag, ".coin_reject"}, int'(rej), int'(m.rej));
      checkOutput({tag, ".dispense"}, int'(disp), int'(m.vend));
      checkOutput({tag, ".change_valid"}, int'(cv), int'(m.paying));
      checkOutput({tag, ".busy"}, int'(bsy), int'(m.vend || m.paying));
      checkOutput({tag, ".credit"}, int'(cr), m.credit);
   endtask

   always @(negedge clock) begin
      compareInst("A", busA.coin_accept, busA.coin_reject, busA.dispense,
                  busA.change_valid, busA.busy, busA.credit, mA);
      compareInst("B", busB.coin_accept, busB.coin_reject, busB.dispense,
                  busB.change_valid, busB.busy, busB.credit, mB);
   end

   // Drive one cycle of inputs; returns 1 time unit after the edge that sampled them.
   task automatic applyStimulus(input bit cv, input logic [1:0] sel, input bit cn, input bit rdy);
      coinValid   = cv;
      coinSel     = sel;
      cancel      = cn;
      changeReady = rdy;
      @(posedge clock);
      #1;
   endtask

   task automatic resetDut();
      reset_n = 1'b0;
      applyStimulus(1'b0, 2'd0, 1'b0, 1'b1);
      applyStimulus(1'b0, 2'd0, 1'b0, 1'b1);
      reset_n = 1'b1;
   endtask

   int cvCount;
   int dispCount;

   initial begin
      $display("[TB] start");
      repeat (3) @(posedge clock);
      #1;
      checkOutput("reset.credit", int'(busA.credit), 0);
      checkOutput("reset.busy", int'(busA.busy), 0);
      checkOutput("reset.change_valid", int'(busA.change_valid), 0);
      reset_n = 1'b1;

      // Coins 10 then 5: exact price, no change
      applyStimulus(1'b1, 2'd3, 1'b0, 1'b1);
      checkOutput("r24.accept1", int'(busA.coin_accept), 1);
      checkOutput("r24.credit10", int'(busA.credit), 10);
      applyStimulus(1'b1, 2'd2, 1'b0, 1'b1);
      checkOutput("r24.accept2", int'(busA.coin_accept), 1);
      checkOutput("r24.dispense", int'(busA.dispense), 1);
      applyStimulus(1'b0, 2'd0, 1'b0, 1'b1);
      checkOutput("r24.creditEnd", int'(busA.credit), 0);
      checkOutput("r24.noChange", int'(busA.change_valid), 0);
      checkOutput("r24.idle", int'(busA.busy), 0);

      // Coins 10 then 10: five change coins
      resetDut();
      applyStimulus(1'b1, 2'd3, 1'b0, 1'b1);
      applyStimulus(1'b1, 2'd3, 1'b0, 1'b1);
      checkOutput("r25.dispense", int'(busA.dispense), 1);
      checkOutput("r25.model20", mA.credit, 20);
      cvCount = 0;
      for (int i = 1; i <= 8; i++) begin
         if (busA.change_valid) cvCount++;
         applyStimulus(1'b0, 2'd0, 1'b0, 1'b1);
         if (i <= 6) checkOutput($sformatf("r25.credit%0d", i), int'(busA.credit), 6 - i);
      end
      checkOutput("r25.changeCycles", cvCount, 5);
      checkOutput("r25.idle", int'(busA.busy), 0);

      // Coins 5, 2 then cancel: refund of seven
      resetDut();
      applyStimulus(1'b1, 2'd2, 1'b0, 1'b1);
      applyStimulus(1'b1, 2'd1, 1'b0, 1'b1);
      checkOutput("r26.credit7", int'(busA.credit), 7);
      applyStimulus(1'b0, 2'd0, 1'b1, 1'b1);
      checkOutput("r26.refundValid", int'(busA.change_valid), 1);
      cvCount   = 0;
      dispCount = int'(busA.dispense);
      for (int i = 0; i < 10; i++) begin
         if (busA.change_valid) cvCount++;
         applyStimulus(1'b0, 2'd0, 1'b0, 1'b1);
         if (busA.dispense) dispCount++;
      end
      checkOutput("r26.refundCoins", cvCount, 7);
      checkOutput("r26.noDispense", dispCount, 0);

      // Change of 3 stalled by the hopper for 4 cycles
      resetDut();
      applyStimulus(1'b1, 2'd0, 1'b0, 1'b1);
      applyStimulus(1'b1, 2'd1, 1'b0, 1'b1);
      applyStimulus(1'b1, 2'd2, 1'b0, 1'b1);
      applyStimulus(1'b1, 2'd3, 1'b0, 1'b1);
      applyStimulus(1'b0, 2'd0, 1'b0, 1'b1);
      checkOutput("r27.credit3", int'(busA.credit), 3);
      checkOutput("r27.model3", mA.credit, 3);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);
         checkOutput($sformatf("r27.hold%0d.credit", i), int'(busA.credit), 3);
         checkOutput($sformatf("r27.hold%0d.valid", i), int'(busA.change_valid), 1);
      end
      cvCount = 0;
      for (int i = 0; i < 6; i++) begin
         if (busA.change_valid) cvCount++;
         applyStimulus(1'b0, 2'd0, 1'b0, 1'b1);
      end
      checkOutput("r27.coinsAfter", cvCount, 3);

      // MAX_CREDIT=20 instance: overflow, coin in CHANGE, coin with cancel
      resetDut();
      applyStimulus(1'b1, 2'd3, 1'b0, 1'b1);
      applyStimulus(1'b1, 2'd1, 1'b0, 1'b1);
      applyStimulus(1'b1, 2'd3, 1'b0, 1'b1);
      checkOutput("r28.overReject", int'(busB.coin_reject), 1);
      checkOutput("r28.overNoAccept", int'(busB.coin_accept), 0);
      checkOutput("r28.credit12", int'(busB.credit), 12);
      applyStimulus(1'b1, 2'd2, 1'b0, 1'b1);
      checkOutput("r28.dispense", int'(busB.dispense), 1);
      applyStimulus(1'b0, 2'd0, 1'b0, 1'b1);
      applyStimulus(1'b1, 2'd3, 1'b0, 1'b0);
      checkOutput("r28.changeReject", int'(busB.coin_reject), 1);
      checkOutput("r28.changeCredit", int'(busB.credit), 2);
      repeat (12) applyStimulus(1'b0, 2'd0, 1'b0, 1'b1);
      applyStimulus(1'b1, 2'd2, 1'b0, 1'b1);
      applyStimulus(1'b1, 2'd3, 1'b1, 1'b1);
      checkOutput("r28.cancelReject", int'(busB.coin_reject), 1);
      checkOutput("r28.cancelNoAccept", int'(busB.coin_accept), 0);
      checkOutput("r28.refundValid", int'(busB.change_valid), 1);
      checkOutput("r28.refundCredit", int'(busB.credit), 5);
      repeat (8) applyStimulus(1'b0, 2'd0, 1'b0, 1'b1);
      checkOutput("r28.refundDone", int'(busB.credit), 0);

      // Reset in the middle of a change payout
      resetDut();
      applyStimulus(1'b1, 2'd1, 1'b0, 1'b1);
      applyStimulus(1'b1, 2'd1, 1'b0, 1'b1);
      applyStimulus(1'b1, 2'd2, 1'b0, 1'b1);
      applyStimulus(1'b1, 2'd3, 1'b0, 1'b1);
      applyStimulus(1'b0, 2'd0, 1'b0, 1'b1);
      checkOutput("r29.credit4", int'(busA.credit), 4);
      reset_n = 1'b0;
      #1;
      checkOutput("r29.rstCredit", int'(busA.credit), 0);
      checkOutput("r29.rstValid", int'(busA.change_valid), 0);
      checkOutput("r29.rstBusy", int'(busA.busy), 0);
      applyStimulus(1'b0, 2'd0, 1'b0, 1'b1);
      applyStimulus(1'b0, 2'd0, 1'b0, 1'b1);
      reset_n = 1'b1;
      checkOutput("r29.afterBusy", int'(busA.busy), 0);
      applyStimulus(1'b1, 2'd2, 1'b0, 1'b1);
      checkOutput("r29.firstAccept", int'(busA.coin_accept), 1);
      checkOutput("r29.firstCredit", int'(busA.credit), 5);

      // Random traffic against the model
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 599) == 0) resetDut();
         applyStimulus($urandom_range(0, 99) < 40, 2'($urandom_range(0, 3)),
                       $urandom_range(0, 99) < 8, $urandom_range(0, 99) < 70);
      end

      @(posedge clock);
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
